// File: rtl/bp_be_pkg.sv
// Shared back-end types: FE exception codes and the issue queue entry.
// Entry struct is declared by macro so the PC width follows vaddr_width_p.
package bp_be_pkg;

  localparam int bp_instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_instr_misaligned   = 2'b00,
    e_itlb_miss          = 2'b01,
    e_instr_access_fault = 2'b10,
    e_instr_page_fault   = 2'b11
  } bp_fe_exception_code_e;

  function automatic int bp_wrap_ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

`define BP_BE_ISSUE_QUEUE_ENTRY_WIDTH(vaddr_width_mp) \
  (32 + (vaddr_width_mp) + 1 + 2)

`define DECLARE_BP_BE_ISSUE_QUEUE_ENTRY_S(vaddr_width_mp) \
  typedef struct packed {                                 \
    logic [31:0]               instr;                     \
    logic [vaddr_width_mp-1:0] pc;                        \
    logic                      exc_not_instr;             \
    bp_fe_exception_code_e     exc;                       \
  } bp_be_issue_queue_entry_s

// File: rtl/bp_be_issue_queue_ptr.sv
// Wrap-bit pointer register: sync reset to 0, load beats increment.
// Ports: clk_i, reset_i, inc_i, load_i, load_val_i, ptr_o.
module bp_be_issue_queue_ptr #(
  parameter int width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  localparam logic [width_p-1:0] one_lp = 1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_o <= '0;
    end else if (load_i) begin
      ptr_o <= load_val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + one_lp;
    end
  end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register file with asynchronous read.
// Ports: write clock/enable/addr/data, read addr, read data. No reset.
module bsg_mem_1r1w #(
  parameter int width_p = 8,
  parameter int els_p = 16,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_be_issue_queue.sv
// In-order FE->BE issue queue with speculative issue, commit, roll, clear.
// Ports: FE ready-valid enqueue, valid-yumi issue, commit/roll/clr
// controls, empty_o/full_o status. Optional same-cycle bypass of an
// enqueue into an empty queue: define BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter int entries_p = 16,
  parameter int vaddr_width_p = 39,
  localparam int instr_width_lp = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      fe_v_i,
  input  logic [instr_width_lp-1:0] fe_instr_i,
  input  logic [vaddr_width_p-1:0]  fe_pc_i,
  input  logic                      fe_exc_not_instr_i,
  input  logic [1:0]                fe_exc_i,
  output logic                      fe_ready_o,

  output logic                      issue_v_o,
  output logic [instr_width_lp-1:0] issue_instr_o,
  output logic [vaddr_width_p-1:0]  issue_pc_o,
  output logic                      issue_exc_not_instr_o,
  output logic [1:0]                issue_exc_o,
  input  logic                      issue_yumi_i,

  input  logic                      commit_v_i,
  input  logic                      roll_v_i,
  input  logic                      clr_v_i,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int ptr_width_lp = $clog2(entries_p) + 1;
  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam int entry_width_lp =
    `BP_BE_ISSUE_QUEUE_ENTRY_WIDTH(vaddr_width_p);

  `DECLARE_BP_BE_ISSUE_QUEUE_ENTRY_S(vaddr_width_p);

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] cptr_adv;
  logic [idx_width_lp-1:0] widx, ridx, cidx;

  logic enq_v, yumi_v, byp_v, rewind_v;

  bp_be_issue_queue_entry_s wr_entry, rd_entry, iss_entry;

  assign widx = wptr[idx_width_lp-1:0];
  assign ridx = rptr[idx_width_lp-1:0];
  assign cidx = cptr[idx_width_lp-1:0];

  assign full_o = (widx == cidx)
               && (wptr[idx_width_lp] != cptr[idx_width_lp]);
  assign empty_o = (rptr == wptr);
  assign fe_ready_o = ~full_o;

  // Commit applies even under clr/roll, so both rewind to the
  // post-commit position.
  assign cptr_adv = cptr
    + {{(ptr_width_lp-1){1'b0}}, commit_v_i};

  assign rewind_v = clr_v_i | roll_v_i;
  assign enq_v = fe_v_i & fe_ready_o & ~clr_v_i;
  assign yumi_v = issue_yumi_i & ~rewind_v;

  always_comb begin
    wr_entry = '0;
    wr_entry.instr = fe_instr_i;
    wr_entry.pc = fe_pc_i;
    wr_entry.exc_not_instr = fe_exc_not_instr_i;
    wr_entry.exc = bp_fe_exception_code_e'(fe_exc_i);
  end

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  // enq_v already excludes clr; full-and-empty cannot enqueue.
  assign byp_v = empty_o & enq_v & ~roll_v_i;
`else
  assign byp_v = 1'b0;
`endif

  assign iss_entry = byp_v ? wr_entry : rd_entry;

  assign issue_v_o = ~empty_o | byp_v;
  assign issue_instr_o = iss_entry.instr;
  assign issue_pc_o = iss_entry.pc;
  assign issue_exc_not_instr_o = iss_entry.exc_not_instr;
  assign issue_exc_o = iss_entry.exc;

  bp_be_issue_queue_ptr #(.width_p(ptr_width_lp)) u_wptr (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .inc_i(enq_v),
    .load_i(clr_v_i),
    .load_val_i(cptr_adv),
    .ptr_o(wptr)
  );

  bp_be_issue_queue_ptr #(.width_p(ptr_width_lp)) u_rptr (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .inc_i(yumi_v),
    .load_i(rewind_v),
    .load_val_i(cptr_adv),
    .ptr_o(rptr)
  );

  bp_be_issue_queue_ptr #(.width_p(ptr_width_lp)) u_cptr (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .inc_i(commit_v_i),
    .load_i(1'b0),
    .load_val_i('0),
    .ptr_o(cptr)
  );

  bsg_mem_1r1w #(
    .width_p(entry_width_lp),
    .els_p(entries_p)
  ) u_mem (
    .w_clk_i(clk_i),
    .w_v_i(enq_v),
    .w_addr_i(widx),
    .w_data_i(wr_entry),
    .r_addr_i(ridx),
    .r_data_o(rd_entry)
  );

  a_yumi_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    issue_yumi_i |-> issue_v_o
  );

  a_commit_issued: assert property (
    @(posedge clk_i) disable iff (reset_i)
    commit_v_i |-> (cptr != rptr)
  );

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue.
// Covers reset, in-order issue, full, roll, clear, wrap, FE exceptions.
module tb_bp_be_issue_queue;
  import bp_be_pkg::*;

  localparam int n_lp = 16;
  localparam int va_lp = 39;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  localparam logic byp = 1'b1;
`else
  localparam logic byp = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             fe_v_i;
  logic [31:0]      fe_instr_i;
  logic [va_lp-1:0] fe_pc_i;
  logic             fe_exc_not_instr_i;
  logic [1:0]       fe_exc_i;
  logic             fe_ready_o;
  logic             issue_v_o;
  logic [31:0]      issue_instr_o;
  logic [va_lp-1:0] issue_pc_o;
  logic             issue_exc_not_instr_o;
  logic [1:0]       issue_exc_o;
  logic             issue_yumi_i;
  logic             commit_v_i;
  logic             roll_v_i;
  logic             clr_v_i;
  logic             empty_o;
  logic             full_o;

  int n_cmp = 0;
  int n_bad = 0;

  bp_be_issue_queue #(
    .entries_p(n_lp),
    .vaddr_width_p(va_lp)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .fe_v_i(fe_v_i),
    .fe_instr_i(fe_instr_i),
    .fe_pc_i(fe_pc_i),
    .fe_exc_not_instr_i(fe_exc_not_instr_i),
    .fe_exc_i(fe_exc_i),
    .fe_ready_o(fe_ready_o),
    .issue_v_o(issue_v_o),
    .issue_instr_o(issue_instr_o),
    .issue_pc_o(issue_pc_o),
    .issue_exc_not_instr_o(issue_exc_not_instr_o),
    .issue_exc_o(issue_exc_o),
    .issue_yumi_i(issue_yumi_i),
    .commit_v_i(commit_v_i),
    .roll_v_i(roll_v_i),
    .clr_v_i(clr_v_i),
    .empty_o(empty_o),
    .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    fe_v_i = 1'b0;
    fe_instr_i = '0;
    fe_pc_i = '0;
    fe_exc_not_instr_i = 1'b0;
    fe_exc_i = '0;
    issue_yumi_i = 1'b0;
    commit_v_i = 1'b0;
    roll_v_i = 1'b0;
    clr_v_i = 1'b0;
  endtask

  task automatic do_reset;
    idle;
    reset_i = 1'b1;
    nxt;
    nxt;
    reset_i = 1'b0;
  endtask

  task automatic push(input logic [va_lp-1:0] pc);
    fe_v_i = 1'b1;
    fe_pc_i = pc;
    fe_instr_i = 32'hA000_0000 | pc[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_i = 1'b1;
    idle;

    // Reset state
    do_reset;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_issue_v", issue_v_o, 0);
    chk("rst_ready", fe_ready_o, 1);

    // Back-to-back enqueue of 4 with yumi whenever valid
    k = 0;
    for (int i = 0; i < 8; i++) begin
      idle;
      if (i < 4) push(39'h100 + 39'(4 * i));
      #1;
      if (i == 0) chk("t1_first_v", issue_v_o, byp);
      if (issue_v_o) begin
        chk("t1_pc", issue_pc_o, 64'h100 + 64'(4 * k));
        chk("t1_instr", issue_instr_o,
            64'hA000_0100 + 64'(4 * k));
        issue_yumi_i = 1'b1;
        k++;
      end
      nxt;
    end
    idle;
    chk("t1_count", k, 4);
    chk("t1_empty", empty_o, 1);

    // Fill to full, drain, then commit frees a slot
    do_reset;
    for (int i = 0; i < 16; i++) begin
      idle;
      push(39'h300 + 39'(4 * i));
      nxt;
    end
    idle;
    chk("t2_full", full_o, 1);
    chk("t2_ready", fe_ready_o, 0);
    chk("t2_empty", empty_o, 0);
    push(39'h7FC);
    nxt;
    idle;
    chk("t2_full_hold", full_o, 1);
    for (int i = 0; i < 16; i++) begin
      idle;
      #1;
      chk("t2_drain_v", issue_v_o, 1);
      chk("t2_drain_pc", issue_pc_o, 64'h300 + 64'(4 * i));
      issue_yumi_i = issue_v_o;
      nxt;
    end
    idle;
    chk("t2_dr_empty", empty_o, 1);
    chk("t2_dr_full", full_o, 1);
    chk("t2_dr_ready", fe_ready_o, 0);
    chk("t2_dr_issue_v", issue_v_o, 0);
    commit_v_i = 1'b1;
    push(39'h800);
    nxt;
    idle;
    chk("t2_cm_ready", fe_ready_o, 1);
    chk("t2_cm_full", full_o, 0);
    chk("t2_cm_empty", empty_o, 1);

    // Enqueue 5, issue 3, commit 1, roll
    do_reset;
    for (int i = 0; i < 5; i++) begin
      idle;
      push(39'h100 + 39'(4 * i));
      nxt;
    end
    for (int i = 0; i < 3; i++) begin
      idle;
      #1;
      chk("t3_iss_pc", issue_pc_o, 64'h100 + 64'(4 * i));
      issue_yumi_i = issue_v_o;
      nxt;
    end
    idle;
    commit_v_i = 1'b1;
    nxt;
    idle;
    roll_v_i = 1'b1;
    #1;
    issue_yumi_i = issue_v_o;
    nxt;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      idle;
      #1;
      if (issue_v_o) begin
        chk("t3_roll_pc", issue_pc_o, 64'h104 + 64'(4 * k));
        issue_yumi_i = 1'b1;
        k++;
      end
      nxt;
    end
    idle;
    chk("t3_count", k, 4);

    // Clear with same-cycle enqueue and commit
    do_reset;
    for (int i = 0; i < 8; i++) begin
      idle;
      push(39'h100 + 39'(4 * i));
      nxt;
    end
    for (int i = 0; i < 2; i++) begin
      idle;
      #1;
      issue_yumi_i = issue_v_o;
      nxt;
    end
    idle;
    clr_v_i = 1'b1;
    commit_v_i = 1'b1;
    push(39'h200);
    #1;
    issue_yumi_i = issue_v_o;
    nxt;
    idle;
    chk("t4_empty", empty_o, 1);
    chk("t4_issue_v", issue_v_o, 0);
    chk("t4_full", full_o, 0);
    chk("t4_ready", fe_ready_o, 1);
    push(39'h300);
    nxt;
    idle;
    #1;
    chk("t4_next_v", issue_v_o, 1);
    chk("t4_next_pc", issue_pc_o, 64'h300);
    issue_yumi_i = issue_v_o;
    nxt;
    idle;
    chk("t4_end_empty", empty_o, 1);

    // 40 enqueue/issue/commit triples across several wraps
    do_reset;
    for (int i = 0; i < 40; i++) begin
      idle;
      push(39'h1000 + 39'(4 * i));
      #1;
      chk("t5_full", full_o, 0);
      nxt;
      idle;
      #1;
      chk("t5_pc", issue_pc_o, 64'h1000 + 64'(4 * i));
      issue_yumi_i = issue_v_o;
      nxt;
      idle;
      commit_v_i = 1'b1;
      nxt;
    end
    idle;
    chk("t5_empty", empty_o, 1);
    chk("t5_ready", fe_ready_o, 1);

    // FE exception entry
    do_reset;
    fe_v_i = 1'b1;
    fe_pc_i = 39'h400;
    fe_exc_not_instr_i = 1'b1;
    fe_exc_i = e_itlb_miss;
    #1;
    chk("t6_same_v", issue_v_o, byp);
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    chk("t6_byp_pc", issue_pc_o, 64'h400);
    chk("t6_byp_exc", issue_exc_o, e_itlb_miss);
    chk("t6_byp_flag", issue_exc_not_instr_o, 1);
`endif
    nxt;
    idle;
    #1;
    chk("t6_v", issue_v_o, 1);
    chk("t6_flag", issue_exc_not_instr_o, 1);
    chk("t6_exc", issue_exc_o, e_itlb_miss);
    chk("t6_pc", issue_pc_o, 64'h400);
    issue_yumi_i = issue_v_o;
    nxt;
    idle;
    chk("t6_empty", empty_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_queue.md
Name: bp_be_issue_queue

Overview:
- Circular buffer between the FE queue interface and the BE instruction decoder.
- Holds fetched instructions, or FE exceptions, in order.
- Presents the oldest unissued entry to the decoder as instr/exception inputs.
- Keeps issued-but-uncommitted entries so the director can replay them (roll) after a mispredict or trap redirect, or discard everything (clear).

Parameters:
- entries_p, 16, queue depth; power of two, ≥ 2.
- vaddr_width_p, 39, PC width.
- instr_width_lp, 32 (localparam, fixed), instruction width.
- ptr_width_lp, $clog2(entries_p)+1 (localparam), pointer width including wrap bit.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fe_v_i  in  1  FE entry valid
- fe_instr_i  in  32  instruction
- fe_pc_i  in  vaddr_width_p  PC of entry
- fe_exc_not_instr_i  in  1  entry is an FE exception, not an instruction
- fe_exc_i  in  2  bp_fe_exception_code_e
- fe_ready_o  out  1  space available (ready-valid)
- issue_v_o  out  1  entry available to decoder
- issue_instr_o  out  32  instruction
- issue_pc_o  out  vaddr_width_p  PC
- issue_exc_not_instr_o  out  1  exception flag
- issue_exc_o  out  2  exception code
- issue_yumi_i  in  1  decoder consumes head (valid-yumi)
- commit_v_i  in  1  retire oldest uncommitted entry
- roll_v_i  in  1  rewind read pointer to commit pointer
- clr_v_i  in  1  flush all entries
- empty_o  out  1  no unissued entries
- full_o  out  1  no free slots

Behaviour:
- Three pointers, each ptr_width_lp wide with a wrap bit: wptr (enqueue), rptr (speculative issue), cptr (commit).
- Occupied region is [cptr, wptr). Issuable region is [rptr, wptr). Invariant: cptr ≤ rptr ≤ wptr (modular).
- full_o = (wptr.idx == cptr.idx) && (wptr.wrap != cptr.wrap).
- empty_o = (rptr == wptr).
- fe_ready_o = ~full_o. issue_v_o = ~empty_o.
- Enqueue when fe_v_i & fe_ready_o: write entry at wptr.idx; wptr += 1. Entry is visible at issue outputs the cycle after the write (1-cycle latency, no bypass).
- Issue: outputs are driven combinationally from entry[rptr.idx]. When issue_yumi_i, rptr += 1.
- issue_yumi_i with issue_v_o=0 is illegal; assert.
- Commit: commit_v_i advances cptr by 1. commit_v_i with cptr == rptr is illegal; assert.
- Roll: rptr ← cptr after any same-cycle commit, i.e. rptr ← cptr+commit_v_i. Same-cycle yumi is ignored. Same-cycle enqueue proceeds.
- Clear: wptr, rptr, cptr ← cptr+commit_v_i. Same-cycle enqueue is dropped; fe_ready_o is still driven by full_o, so FE must not count the dropped beat. Same-cycle yumi is ignored.
- Priority: reset > clr > roll > normal. Commit is applied in all non-reset cases.
- Simultaneous enqueue and commit when full: the commit frees a slot, but fe_ready_o stays 0 that cycle (no combinational path from commit to ready).
- Wrap-around: pointers increment modulo 2*entries_p; index = low bits.
- Reset: all pointers 0. Outputs after reset: empty_o=1, full_o=0, issue_v_o=0, fe_ready_o=1. Payload outputs are don't-care while issue_v_o=0. Storage is not reset.
- Reset mid-operation: all contents discarded at the next edge; no commit or issue side effects.

Optional Feature:
- BP_BE_ISSUE_QUEUE_BYPASS_EN defined:
  - When empty_o & fe_v_i, the FE payload is muxed directly onto the issue outputs and issue_v_o=1 in the same cycle.
  - The entry is still written.
  - If issue_yumi_i, rptr advances with wptr in the same cycle.
  - Bypass is suppressed when clr_v_i or roll_v_i is asserted.
- Macro not defined: strict 1-cycle latency as in Behaviour.

Decomposition:
- Shared package (bp_be_pkg): bp_be_issue_queue_entry_s {instr, pc, exc_not_instr, exc}.
- Its width macro, `bp_be_issue_queue_entry_width(vaddr_width_p), goes in the same package file.
- Storage: bsg_mem_1r1w, async read, entries_p deep.
- One natural sub-module: bp_be_issue_queue_ptr, a wrap-bit pointer register with increment and load-value/load-enable, instantiated three times.

Test Plan:
- Reset, then enqueue PCs 0x100..0x10C (4 entries) back-to-back with yumi held high → issue_v_o rises the cycle after the first write; PCs issue in order 0x100..0x10C; empty_o=1 after the 4th yumi.
- Fill 16 entries with no commit, then drain all via yumi → full_o=1, fe_ready_o=0 after the 16th enqueue, and full_o stays 1 after the drain. Then commit ×1 → fe_ready_o=1 the next cycle.
- Enqueue 5, issue 3, commit 1, assert roll_v_i → next issue is entry #2 (PC 0x104); 4 entries remain issuable.
- Assert clr_v_i together with fe_v_i (PC 0x200) on a half-full queue → next cycle empty_o=1; entry 0x200 is never issued.
- Wrap test: run 40 enqueue/issue/commit triples → PC sequence is intact across 2+ wraps; full_o is never asserted spuriously.
- FE exception entry (exc_not_instr=1, exc=e_itlb_miss) → issue_exc_not_instr_o=1, issue_exc_o=e_itlb_miss. With BYPASS_EN, an empty-queue enqueue is visible the same cycle.
